multiplier_core: RTL and testbench
==================================

MULTIPLIER_CORE -- requirements
Module: multiplier_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, which sets the operand width in bits; the legal range is 2 to 16.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk  input  1  rising-edge clock SHALL be provided.
REQ-004 Port rst_n  input  1  asynchronous active-low reset SHALL be provided.
REQ-005 Port A  input  WIDTH  multiplicand SHALL be provided.
REQ-006 Port B  input  WIDTH  multiplier SHALL be provided.
REQ-007 Port in_valid  input  1  marks A/B as valid this cycle SHALL be provided.
REQ-008 Port P  output  2*WIDTH  registered product SHALL be provided.
REQ-009 Port out_valid  output  1  marks P as updated this cycle SHALL be provided.

Function
REQ-010 The block SHALL compute the full-precision product A*B into 2*WIDTH bits, with no truncation, overflow or saturation.
REQ-011 The product SHALL be formed by an array of partial products (A & B[i], shifted by i) summed through a ripple/carry-save adder array; the '*' operator SHALL NOT be used.
REQ-012 At a rising clk edge with in_valid=1, the block SHALL load P with the product of the A/B values sampled at that edge and set out_valid=1; latency is exactly 1 cycle.
REQ-013 At a rising clk edge with in_valid=0, P SHALL hold its previous value and out_valid SHALL be 0.
REQ-014 With in_valid held high on consecutive cycles, the block SHALL accept one new operand pair every cycle (full throughput, no back-pressure).
REQ-015 Changes on A/B between clock edges SHALL NOT affect P until the next qualifying edge.
REQ-016 Operand value 0 on either input SHALL yield P=0; maximum operands SHALL yield (2^WIDTH-1)^2 (9 for WIDTH=2).

Reset
REQ-017 When rst_n=0, the block SHALL force P=0 and out_valid=0 immediately, without waiting for a clock edge.
REQ-018 Reset asserted while an operation is in flight SHALL discard that operation; no out_valid pulse SHALL follow the reset.
REQ-019 After rst_n is released, the first in_valid=1 edge SHALL produce a normal result one cycle later.

Configuration
REQ-020 The block SHALL support the macro MULT_SIGNED_EN, which compiles in signed operation.
REQ-021 When MULT_SIGNED_EN is defined, A, B and P SHALL be treated as two's complement and the product SHALL be computed with Baugh-Wooley partial-product correction.
REQ-022 When MULT_SIGNED_EN is undefined, A, B and P SHALL be unsigned.
REQ-023 Timing and handshake SHALL be identical in both modes.

Structure
REQ-024 A shared package multiplier_pkg SHALL hold the default WIDTH constant and a function or localparam giving the product width (2*WIDTH).
REQ-025 A single sub-module full_adder (inputs a, b, cin; outputs sum, cout) SHALL be instantiated by generate loops to form the adder array.
REQ-026 The output register, out_valid register and reset logic SHALL reside in multiplier_core.

Verification
REQ-027 Scenario, unsigned, WIDTH=2: A=2, B=3, in_valid=1 -> the next cycle SHALL show P=6 and out_valid=1.
REQ-028 Scenario, unsigned, WIDTH=2: apply the stream (1,1), (3,3), (1,2), (3,1) back-to-back -> P SHALL be 1, 9, 2, 3 on consecutive cycles with out_valid held at 1.
REQ-029 Scenario, unsigned: run all 16 A/B combinations for WIDTH=2 and random pairs for WIDTH=8 -> each result SHALL match the reference product.
REQ-030 Scenario: in_valid=0 with A/B toggling -> P SHALL hold its prior value and out_valid SHALL be 0.
REQ-031 Scenario: assert rst_n=0 between an in_valid edge and the result -> P=0 and out_valid=0 SHALL appear immediately, with no later pulse.
REQ-032 Scenario, MULT_SIGNED_EN, WIDTH=2: A=2'b11 (-1), B=2'b10 (-2) -> the result SHALL be P=4'b0010; A=2'b10, B=2'b10 -> the result SHALL be P=4'b0100.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared constants for the array multiplier: default operand width and product width.
package multiplier_pkg;

  localparam int DEFAULT_WIDTH = 2;

  function automatic int prod_width(input int w);
    return w + w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, replicated by multiplier_core to build its adder array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multiplier_core.sv
// Registered array multiplier: AND-gate partial products summed by rows of full adders.
// Define MULT_SIGNED_EN for two's-complement operands using Baugh-Wooley correction.
module multiplier_core
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic                         in_valid,
  output logic [prod_width(WIDTH)-1:0] P,
  output logic                         out_valid
);

  localparam int PW = prod_width(WIDTH);
`ifdef MULT_SIGNED_EN
  // Extra row carries the Baugh-Wooley constant (1 at bit WIDTH and bit PW-1).
  localparam int NROWS = WIDTH + 1;
`else
  localparam int NROWS = WIDTH;
`endif

  wire logic [PW-1:0] row [NROWS];
  wire logic [PW-1:0] acc [NROWS];
  wire logic [PW:0]   cy  [1:NROWS-1];
  wire logic [NROWS-1:1] unused_top_carry;

  logic [PW-1:0] p_q, p_d;
  logic          out_valid_q, out_valid_d;

  genvar gi, gj, gr, gb;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp_row
      for (gj = 0; gj < PW; gj++) begin : g_pp_bit
        if (gj >= gi && gj < gi + WIDTH) begin : g_active
`ifdef MULT_SIGNED_EN
          if ((gi == WIDTH - 1) != (gj - gi == WIDTH - 1)) begin : g_inv
            assign row[gi][gj] = ~(A[gj-gi] & B[gi]);
          end else begin : g_pos
            assign row[gi][gj] = A[gj-gi] & B[gi];
          end
`else
          assign row[gi][gj] = A[gj-gi] & B[gi];
`endif
        end else begin : g_zero
          assign row[gi][gj] = 1'b0;
        end
      end
    end

`ifdef MULT_SIGNED_EN
    assign row[WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`endif

    assign acc[0] = row[0];

    // Each adder row folds one more partial-product row into the running sum;
    // the product always fits in PW bits, so the final carry is dropped.
    for (gr = 1; gr < NROWS; gr++) begin : g_add_row
      assign cy[gr][0] = 1'b0;
      for (gb = 0; gb < PW; gb++) begin : g_add_bit
        full_adder u_fa (
          .a   (acc[gr-1][gb]),
          .b   (row[gr][gb]),
          .cin (cy[gr][gb]),
          .sum (acc[gr][gb]),
          .cout(cy[gr][gb+1])
        );
      end
      assign unused_top_carry[gr] = cy[gr][PW];
    end
  endgenerate

  always_comb begin
    p_d         = p_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      p_d         = acc[NROWS-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_core.sv
// Directed bench for multiplier_core at WIDTH=2 and WIDTH=8; follows MULT_SIGNED_EN if defined.
module tb_multiplier_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        v2 = 1'b0;
  logic [3:0]  p2;
  logic        ov2;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        v8 = 1'b0;
  logic [15:0] p8;
  logic        ov8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multiplier_core #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .in_valid(v2), .P(p2), .out_valid(ov2)
  );
  multiplier_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(v8), .P(p8), .out_valid(ov8)
  );

  function automatic logic [3:0] ref2(input logic [1:0] a, input logic [1:0] b);
    logic [3:0] ea, eb;
`ifdef MULT_SIGNED_EN
    ea = {{2{a[1]}}, a};
    eb = {{2{b[1]}}, b};
`else
    ea = {2'b00, a};
    eb = {2'b00, b};
`endif
    return 4'(ea * eb);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
`ifdef MULT_SIGNED_EN
    ea = {{8{a[7]}}, a};
    eb = {{8{b[7]}}, b};
`else
    ea = {8'h00, a};
    eb = {8'h00, b};
`endif
    return 16'(ea * eb);
  endfunction

  // Drive one WIDTH=2 pair at the falling edge, then look just after the next rising edge.
  task automatic step2(input logic [1:0] a, input logic [1:0] b, input logic v);
    @(negedge clk);
    a2 = a; b2 = b; v2 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (p2 !== 4'd0 || ov2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_w2: P=%0d out_valid=%0b, required P=0 out_valid=0", p2, ov2);
    end
    tests++;
    if (p8 !== 16'd0 || ov8 !== 1'b0) begin
      fails++;
      $display("FAIL reset_w8: P=%0d out_valid=%0b, required P=0 out_valid=0", p8, ov8);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

`ifndef MULT_SIGNED_EN
  task automatic test_single();
    step2(2'd2, 2'd3, 1'b1);
    tests++;
    if (p2 !== 4'd6 || ov2 !== 1'b1) begin
      fails++;
      $display("FAIL single_2x3: P=%0d out_valid=%0b, required P=6 out_valid=1", p2, ov2);
    end
    $display("[TB] single 2*3 -> P=%0d out_valid=%0b", p2, ov2);
  endtask

  task automatic test_back_to_back();
    logic [1:0] va [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [1:0] vb [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
    logic [3:0] ve [4] = '{4'd1, 4'd9, 4'd2, 4'd3};
    for (int i = 0; i < 4; i++) begin
      step2(va[i], vb[i], 1'b1);
      tests++;
      if (p2 !== ve[i] || ov2 !== 1'b1) begin
        fails++;
        $display("FAIL back_to_back[%0d]: P=%0d out_valid=%0b, required P=%0d out_valid=1",
                 i, p2, ov2, ve[i]);
      end
      $display("[TB] b2b %0d*%0d -> P=%0d", va[i], vb[i], p2);
    end
  endtask
`else
  task automatic test_signed();
    step2(2'b11, 2'b10, 1'b1);
    tests++;
    if (p2 !== 4'b0010 || ov2 !== 1'b1) begin
      fails++;
      $display("FAIL signed_m1_m2: P=%b out_valid=%0b, required P=0010 out_valid=1", p2, ov2);
    end
    $display("[TB] signed -1*-2 -> P=%b", p2);
    step2(2'b10, 2'b10, 1'b1);
    tests++;
    if (p2 !== 4'b0100 || ov2 !== 1'b1) begin
      fails++;
      $display("FAIL signed_m2_m2: P=%b out_valid=%0b, required P=0100 out_valid=1", p2, ov2);
    end
    $display("[TB] signed -2*-2 -> P=%b", p2);
  endtask
`endif

  task automatic test_exhaustive_w2();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] a, b;
      logic [3:0] exp;
      a = 2'(i >> 2);
      b = 2'(i);
      exp = ref2(a, b);
      step2(a, b, 1'b1);
      tests++;
      if (p2 !== exp || ov2 !== 1'b1) begin
        fails++;
        $display("FAIL exhaustive_w2 %0d*%0d: P=%0d out_valid=%0b, required P=%0d out_valid=1",
                 a, b, p2, ov2, exp);
      end
      $display("[TB] w2 %0d*%0d -> P=%0d", a, b, p2);
    end
    @(negedge clk);
    v2 = 1'b0;
  endtask

  task automatic test_random_w8();
    logic [7:0] ta [12] = '{8'd0, 8'd255, 8'd255, 8'd1, 8'd128, 8'd0,
                            8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] tb_ [12] = '{8'd200, 8'd0, 8'd255, 8'd255, 8'd128, 8'd0,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 6; i < 12; i++) begin
      ta[i]  = 8'($urandom_range(0, 255));
      tb_[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 12; i++) begin
      logic [15:0] exp;
      exp = ref8(ta[i], tb_[i]);
      @(negedge clk);
      a8 = ta[i]; b8 = tb_[i]; v8 = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (p8 !== exp || ov8 !== 1'b1) begin
        fails++;
        $display("FAIL random_w8 %0d*%0d: P=%0d out_valid=%0b, required P=%0d out_valid=1",
                 ta[i], tb_[i], p8, ov8, exp);
      end
      $display("[TB] w8 %0d*%0d -> P=%0d", ta[i], tb_[i], p8);
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_hold();
    logic [3:0] exp;
    exp = ref2(2'd3, 2'd3);
    step2(2'd3, 2'd3, 1'b1);
    tests++;
    if (p2 !== exp || ov2 !== 1'b1) begin
      fails++;
      $display("FAIL hold_load: P=%0d out_valid=%0b, required P=%0d out_valid=1", p2, ov2, exp);
    end
    for (int i = 0; i < 4; i++) begin
      step2(2'(i), 2'(i + 1), 1'b0);
      #2 a2 = ~a2;
      b2 = ~b2;
      #1;
      tests++;
      if (p2 !== exp || ov2 !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: P=%0d out_valid=%0b, required P=%0d out_valid=0",
                 i, p2, ov2, exp);
      end
      $display("[TB] hold %0d -> P=%0d out_valid=%0b", i, p2, ov2);
    end
  endtask

  task automatic test_reset_inflight();
    logic [3:0] exp;
    step2(2'd3, 2'd3, 1'b1);
    @(negedge clk);
    a2 = 2'd2; b2 = 2'd3; v2 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (p2 !== 4'd0 || ov2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: P=%0d out_valid=%0b, required P=0 out_valid=0", p2, ov2);
    end
    v2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (p2 !== 4'd0 || ov2 !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_pulse[%0d]: P=%0d out_valid=%0b, required P=0 out_valid=0",
                 i, p2, ov2);
      end
    end
    $display("[TB] reset in flight -> P=%0d out_valid=%0b", p2, ov2);
    exp = ref2(2'd1, 2'd3);
    step2(2'd1, 2'd3, 1'b1);
    tests++;
    if (p2 !== exp || ov2 !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_first: P=%0d out_valid=%0b, required P=%0d out_valid=1",
               p2, ov2, exp);
    end
    $display("[TB] post-reset 1*3 -> P=%0d", p2);
    @(negedge clk);
    v2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef MULT_SIGNED_EN
    test_single();
    test_back_to_back();
`else
    test_signed();
`endif
    test_exhaustive_w2();
    test_random_w8();
    test_hold();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
